// File: rtl/encoder_io_pkg.sv
// ----------------------------------------------------------------------------
// encoder_io_pkg
// Shared definitions for the encoder IO bank:
//   - 2-bit encoding of the per-channel direction state machine
//   - default values for the bank parameters
//   - cnt_w(): counter width helper (at least 1 bit)
// Optional feature macro used by the bank: ENC_IO_FILT_EN (inbound glitch filter).
// ----------------------------------------------------------------------------
package encoder_io_pkg;

    // Direction state machine encoding
    localparam logic [1:0] S_IN     = 2'd0;  // line owned by the encoder
    localparam logic [1:0] S_TO_OUT = 2'd1;  // dead time before the FPGA drives
    localparam logic [1:0] S_OUT    = 2'd2;  // line driven by the FPGA
    localparam logic [1:0] S_TO_IN  = 2'd3;  // dead time after the FPGA released

    // Default parameter values
    localparam int CH_NUM_DEF   = 3;
    localparam int DEAD_CYC_DEF = 4;
    localparam int FILT_LEN_DEF = 3;

    // Width of a counter that must hold 0 .. n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encoder_io_chan.sv
// ----------------------------------------------------------------------------
// encoder_io_chan
// One bidirectional encoder line: direction state machine with turnaround
// dead time, registered drive path, two-flop synchroniser and (optionally)
// a glitch filter on the inbound path.
//
// Optional feature: ENC_IO_FILT_EN
//   defined   -> data_in changes only after FILT_LEN consecutive differing
//                synchronised samples taken while the line is an input
//   undefined -> data_in follows the second synchroniser flop while the line
//                is an input (FILT_LEN ignored)
//
// Ports
//   clk       in   encoder-domain clock
//   rst       in   asynchronous reset, active-high
//   dir_req   in   requested direction, 1 = FPGA drives the line
//   data_out  in   data to drive onto the line
//   pad_in    in   raw (asynchronous) pad value
//   pad_out   out  registered drive data
//   pad_oe    out  registered output enable
//   data_in   out  synchronised / filtered line value
//   busy      out  line is in a turnaround dead time
//   dir_ack   out  1 = output direction settled
// ----------------------------------------------------------------------------
module encoder_io_chan
    import encoder_io_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic dir_req,
    input  logic data_out,
    input  logic pad_in,
    output logic pad_out,
    output logic pad_oe,
    output logic data_in,
    output logic busy,
    output logic dir_ack
);

    localparam int              DW        = cnt_w(DEAD_CYC);
    localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_CYC - 1);

    // Lengths below 1 have no meaningful hardware; they leave a visible
    // marker scope in the elaborated hierarchy.
    if (DEAD_CYC < 1 || FILT_LEN < 1) begin : g_illegal_param
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] dead_cnt;
    logic [DW-1:0] dead_cnt_nxt;
    logic          pad_oe_nxt;
    logic          busy_nxt;
    logic          dir_ack_nxt;
    logic          sync_p0;
    logic          sync_p1;

    // State register; the direction outputs are registered from the
    // next-state decode so the IO buffer enable never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IN;
            dead_cnt <= '0;
            pad_oe   <= 1'b0;
            busy     <= 1'b0;
            dir_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_cnt_nxt;
            pad_oe   <= pad_oe_nxt;
            busy     <= busy_nxt;
            dir_ack  <= dir_ack_nxt;
        end
    end

    // Next-state logic. The dead counter is tested before it decrements,
    // so a load of DEAD_CYC-1 yields exactly DEAD_CYC turnaround edges and
    // the counter never wraps below zero.
    always_comb begin
        state_nxt    = state;
        dead_cnt_nxt = dead_cnt;
        case (state)
            S_IN: begin
                if (dir_req) begin
                    state_nxt    = S_TO_OUT;
                    dead_cnt_nxt = DEAD_LOAD;
                end
            end
            S_TO_OUT: begin
                // A dropped request wins over an expiring count.
                if (!dir_req) begin
                    state_nxt    = S_IN;
                    dead_cnt_nxt = '0;
                end else if (dead_cnt == '0) begin
                    state_nxt = S_OUT;
                end else begin
                    dead_cnt_nxt = dead_cnt - DW'(1);
                end
            end
            S_OUT: begin
                if (!dir_req) begin
                    state_nxt    = S_TO_IN;
                    dead_cnt_nxt = DEAD_LOAD;
                end
            end
            S_TO_IN: begin
                // Not abortable: a new request is picked up from S_IN.
                if (dead_cnt == '0) begin
                    state_nxt = S_IN;
                end else begin
                    dead_cnt_nxt = dead_cnt - DW'(1);
                end
            end
            default: begin
                state_nxt    = S_IN;
                dead_cnt_nxt = '0;
            end
        endcase
    end

    // Output decode of the next state
    always_comb begin
        pad_oe_nxt  = (state_nxt == S_OUT);
        dir_ack_nxt = (state_nxt == S_OUT);
        busy_nxt    = (state_nxt == S_TO_OUT) || (state_nxt == S_TO_IN);
    end

    // Drive data is registered every cycle so the first driven value is current.
    // The pad is brought into the clock domain through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_out <= 1'b0;
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            pad_out <= data_out;
            sync_p0 <= pad_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef ENC_IO_FILT_EN
    localparam int            FW        = cnt_w(FILT_LEN);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

    logic [FW-1:0] filt_cnt;

    // Counts consecutive cycles where the synchronised value disagrees with
    // data_in; only an input line may update, otherwise the filter is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
            data_in  <= 1'b0;
        end else if (state != S_IN) begin
            filt_cnt <= '0;
        end else if (sync_p1 == data_in) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            data_in  <= sync_p1;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end
`else
    logic data_hold;

    // Without the filter the synchroniser output is passed straight through
    // while the line is an input, and frozen at its last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_hold <= 1'b0;
        end else begin
            data_hold <= data_in;
        end
    end

    assign data_in = (state == S_IN) ? sync_p1 : data_hold;
`endif

endmodule

// File: rtl/encoder_io_bank.sv
// ----------------------------------------------------------------------------
// encoder_io_bank
// Bank of CH_NUM independent bidirectional encoder lines placed between
// encoder_control and the FPGA IO buffers. Each line has its own direction
// state machine with DEAD_CYC turnaround cycles, so the FPGA and the encoder
// never drive a line at the same time.
//
// Optional feature: ENC_IO_FILT_EN (inbound glitch filter of FILT_LEN cycles,
// see encoder_io_chan).
//
// Ports (all vectors are CH_NUM wide, bit i = line i)
//   clk       in   100 MHz encoder-domain clock
//   rst       in   asynchronous reset, active-high
//   dir_req   in   requested direction, 1 = FPGA drives the line
//   data_out  in   data to drive onto each line
//   pad_in    in   raw pad value from the IO buffer (asynchronous)
//   pad_out   out  registered drive data to the IO buffer
//   pad_oe    out  registered output enable (also the *_out_able pins)
//   data_in   out  synchronised, filtered line value
//   busy      out  line is in turnaround
//   dir_ack   out  settled direction, 1 = output settled
// ----------------------------------------------------------------------------
module encoder_io_bank
    import encoder_io_pkg::*;
#(
    parameter int CH_NUM   = CH_NUM_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] dir_req,
    input  logic [CH_NUM-1:0] data_out,
    input  logic [CH_NUM-1:0] pad_in,
    output logic [CH_NUM-1:0] pad_out,
    output logic [CH_NUM-1:0] pad_oe,
    output logic [CH_NUM-1:0] data_in,
    output logic [CH_NUM-1:0] busy,
    output logic [CH_NUM-1:0] dir_ack
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        encoder_io_chan #(
            .DEAD_CYC (DEAD_CYC),
            .FILT_LEN (FILT_LEN)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .dir_req  (dir_req[i]),
            .data_out (data_out[i]),
            .pad_in   (pad_in[i]),
            .pad_out  (pad_out[i]),
            .pad_oe   (pad_oe[i]),
            .data_in  (data_in[i]),
            .busy     (busy[i]),
            .dir_ack  (dir_ack[i])
        );
    end

endmodule

// File: tb/tb_encoder_io_bank.sv
// ----------------------------------------------------------------------------
// tb_encoder_io_bank
// Self-checking bench for encoder_io_bank (CH_NUM=3, DEAD_CYC=4, FILT_LEN=3).
// A behavioural model (timestamps for turnaround, a pad-sample history for
// the synchroniser, a run-length rule for the filter) is checked against the
// DUT on every falling edge; directed literal checks pin the model.
// Follows ENC_IO_FILT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_encoder_io_bank;

    localparam int CH   = 3;
    localparam int DEAD = 4;
    localparam int FILT = 3;

`ifdef ENC_IO_FILT_EN
    localparam bit FILT_ON = 1'b1;
    localparam int LAT     = 2 + FILT;
`else
    localparam bit FILT_ON = 1'b0;
    localparam int LAT     = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] dir_req;
    logic [CH-1:0] data_out;
    logic [CH-1:0] pad_in;
    logic [CH-1:0] pad_out;
    logic [CH-1:0] pad_oe;
    logic [CH-1:0] data_in;
    logic [CH-1:0] busy;
    logic [CH-1:0] dir_ack;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    always #5 clk = ~clk;

    encoder_io_bank #(
        .CH_NUM   (CH),
        .DEAD_CYC (DEAD),
        .FILT_LEN (FILT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dir_req  (dir_req),
        .data_out (data_out),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oe   (pad_oe),
        .data_in  (data_in),
        .busy     (busy),
        .dir_ack  (dir_ack)
    );

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum logic [1:0] {M_IN, M_TO_OUT, M_OUT, M_TO_IN} mode_t;

    mode_t         mode    [CH];
    int            t_start [CH];   // edge number at which the turnaround began
    int            run     [CH];   // consecutive qualifying filter samples
    bit            hist0   [CH];   // pad sampled one edge ago
    bit            hist1   [CH];   // pad sampled two edges ago
    int            edge_no;
    bit            synced;
    logic [CH-1:0] m_pad_out;
    logic [CH-1:0] m_data_in;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                mode[i]    = M_IN;
                t_start[i] = 0;
                run[i]     = 0;
                hist0[i]   = 1'b0;
                hist1[i]   = 1'b0;
            end
            edge_no   = 0;
            m_pad_out = '0;
            m_data_in = '0;
        end else begin
            edge_no++;
            for (int i = 0; i < CH; i++) begin
                // filter acts on the value synchronised before this edge
                synced = hist1[i];
                if (FILT_ON) begin
                    if (mode[i] == M_IN && synced != m_data_in[i]) run[i]++;
                    else run[i] = 0;
                    if (run[i] >= FILT) begin
                        m_data_in[i] = synced;
                        run[i]       = 0;
                    end
                end
                hist1[i] = hist0[i];
                hist0[i] = pad_in[i];

                case (mode[i])
                    M_IN:     if (dir_req[i]) begin mode[i] = M_TO_OUT; t_start[i] = edge_no; end
                    M_TO_OUT: if (!dir_req[i]) mode[i] = M_IN;
                              else if (edge_no - t_start[i] >= DEAD) mode[i] = M_OUT;
                    M_OUT:    if (!dir_req[i]) begin mode[i] = M_TO_IN; t_start[i] = edge_no; end
                    M_TO_IN:  if (edge_no - t_start[i] >= DEAD) mode[i] = M_IN;
                    default:  mode[i] = M_IN;
                endcase

                // unfiltered path: follows the synchroniser whenever the line is an input
                if (!FILT_ON && mode[i] == M_IN) m_data_in[i] = hist1[i];
                m_pad_out[i] = data_out[i];
            end
        end
    end

    logic [CH-1:0] e_oe, e_busy, e_ack;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < CH; i++) begin
                e_oe[i]   = (mode[i] == M_OUT);
                e_ack[i]  = (mode[i] == M_OUT);
                e_busy[i] = (mode[i] == M_TO_OUT) || (mode[i] == M_TO_IN);
            end
            check("mdl_pad_oe",  pad_oe,  e_oe);
            check("mdl_dir_ack", dir_ack, e_ack);
            check("mdl_busy",    busy,    e_busy);
            check("mdl_pad_out", pad_out, m_pad_out);
            check("mdl_data_in", data_in, m_data_in);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        dir_req  = '0;
        data_out = '0;
        pad_in   = '1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick(2);

        // 1: reset state, then pad=111 reaches data_in LAT edges after release
        check("rst_pad_oe",  pad_oe,  3'b000);
        check("rst_busy",    busy,    3'b000);
        check("rst_dir_ack", dir_ack, 3'b000);
        check("rst_data_in", data_in, 3'b000);
        check("rst_pad_out", pad_out, 3'b000);
        rst = 1'b0;
        tick(LAT - 1);
        check("t1_data_in_early", data_in, 3'b000);
        tick(1);
        check("t1_data_in", data_in, 3'b111);

        // 2: ch0 to output, then back to input
        dir_req  = 3'b001;
        data_out = 3'b001;
        tick(1);
        check("t2_busy_start",  busy,    3'b001);
        check("t2_oe_start",    pad_oe,  3'b000);
        check("t2_pad_out",     pad_out, 3'b001);
        tick(3);
        check("t2_busy_last",   busy,    3'b001);
        check("t2_oe_last",     pad_oe,  3'b000);
        tick(1);
        check("t2_oe_on",       pad_oe,  3'b001);
        check("t2_ack_on",      dir_ack, 3'b001);
        check("t2_busy_done",   busy,    3'b000);
        dir_req = 3'b000;
        tick(1);
        check("t2_oe_release",  pad_oe,  3'b000);
        check("t2_ack_release", dir_ack, 3'b000);
        check("t2_busy_toin",   busy,    3'b001);
        tick(3);
        check("t2_busy_toin_last", busy, 3'b001);
        tick(1);
        check("t2_busy_in",     busy,    3'b000);

        // 3: 2-cycle request on ch1 aborts the turnaround
        dir_req = 3'b010;
        tick(2);
        check("t3_busy_pulse", busy, 3'b010);
        dir_req = 3'b000;
        tick(1);
        check("t3_busy_abort", busy, 3'b000);
        tick(4);
        check("t3_oe_never",   pad_oe, 3'b000);

        // 4: glitch rejection and stable change on the input path
        pad_in = 3'b000;
        tick(8);
        check("t4_settle_0", data_in, 3'b000);
        pad_in = 3'b111;
        tick(2);
        pad_in = 3'b000;
        check("t4_pulse2_now", data_in, FILT_ON ? 3'b000 : 3'b111);
        tick(6);
        check("t4_pulse2_after", data_in, 3'b000);
        pad_in = 3'b111;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 3) pad_in = 3'b000;
            if (k == LAT - 1) check("t4_stable_early", data_in, 3'b000);
            if (k == LAT)     check("t4_stable",       data_in, 3'b111);
        end
        tick(10);
        check("t4_settle_1", data_in, 3'b000);

        // 5: ch2 out while pad rises (ch2 holds), then ch0 in / ch2 out on one edge
        dir_req = 3'b100;
        pad_in  = 3'b111;
        tick(6);
        check("t5_ch2_out",  pad_oe,  3'b100);
        check("t5_hold",     data_in, 3'b011);
        dir_req = 3'b001;
        tick(1);
        check("t5_oe_swap",  pad_oe,  3'b000);
        check("t5_busy_swap", busy,   3'b101);
        tick(3);
        check("t5_busy_last", busy,   3'b101);
        tick(1);
        check("t5_oe_ch0",   pad_oe,  3'b001);
        check("t5_ack_ch0",  dir_ack, 3'b001);
        check("t5_busy_end", busy,    3'b000);

        // S_TO_IN is not abortable; a new request is serviced afterwards
        dir_req = 3'b000;
        tick(1);
        dir_req = 3'b001;
        tick(4);
        check("t5_toin_done",  busy, 3'b000);
        tick(1);
        check("t5_rerequest",  busy, 3'b001);

        // 6: asynchronous reset in the middle of S_TO_OUT
        #2 rst = 1'b1;
        #1;
        check("t6_arst_busy",    busy,    3'b000);
        check("t6_arst_pad_out", pad_out, 3'b000);
        check("t6_arst_data_in", data_in, 3'b000);
        check("t6_arst_oe",      pad_oe,  3'b000);
        tick(2);
        rst      = 1'b0;
        dir_req  = 3'b000;
        pad_in   = 3'b000;
        data_out = 3'b110;
        tick(1);
        check("t6_pad_out", pad_out, 3'b110);
        tick(2);
        // single-cycle pad glitch on ch1
        pad_in = 3'b010;
        tick(1);
        pad_in = 3'b000;
        tick(1);
        check("t6_glitch_now",   data_in, FILT_ON ? 3'b000 : 3'b010);
        tick(1);
        check("t6_glitch_after", data_in, 3'b000);
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
